// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 32-way round-robin arbiter.
// Used by rr_pick32 and rr_arbiter32.
package rr_arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 31->0.
// Rotates so ptr lands on bit 0, finds the lowest set bit, then adds ptr back.
module rr_pick32
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;

  assign doubled = {req_i, req_i};
  assign rotated = doubled[ptr_i +: N_REQ];

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
  end

  assign any_o    = |req_i;
  assign winner_o = offset + ptr_i;

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter over 32 requesters with hold-until-release grants.
// Define RR_ARB_TIMEOUT_EN to build the hold counter and forced release after TIMEOUT cycles.
module rr_arbiter32
  import rr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             timeout_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
    $error("rr_arbiter32: TIMEOUT must be in 1..255");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grantIdx_q;
  logic             grantValid_q;
  logic [IDX_W-1:0] pickPtr;
  logic [IDX_W-1:0] winner;
  logic             anyReq;
  logic             forceRel;
  logic             doRelease;

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`endif

  // On release the next pick searches from just past the owner in the same edge.
  always_comb begin
    forceRel = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    forceRel = (state_q == GRANT) && !release_i && (cnt_q == CNT_W'(TIMEOUT - 1));
`endif
    doRelease = (state_q == GRANT) && (release_i || forceRel);
    pickPtr   = doRelease ? (grantIdx_q + IDX_W'(1)) : ptr_q;
  end

  rr_pick32 uPick (
    .req_i   (req_i),
    .ptr_i   (pickPtr),
    .any_o   (anyReq),
    .winner_o(winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grantValid_q <= 1'b0;
      grantIdx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            grantIdx_q   <= winner;
            grantValid_q <= 1'b1;
            state_q      <= GRANT;
          end
        end
        GRANT: begin
          if (doRelease) begin
            ptr_q <= pickPtr;
            if (anyReq) begin
              grantIdx_q <= winner;
            end else begin
              grantValid_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Counter restarts on each new grant; timeout pulses alongside the forced handover.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forceRel;
      if (state_q == IDLE || doRelease) cnt_q <= '0;
      else cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_valid_o = grantValid_q;
  assign grant_idx_o   = grantIdx_q;

endmodule

// File: doc/rr_arbiter32.md
# rr_arbiter32

Round-robin arbiter over 32 requesters. Registers a 5-bit grant index that drives the `A` input of `decoder5to32`, whose 32-bit output becomes the one-hot grant bus. The grant is held until the owner releases it. The priority pointer then rotates past the last winner, so no requester starves.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum hold cycles before a forced release. Used only when `RR_ARB_TIMEOUT_EN` is defined; must satisfy 1..255.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 32: request vector, bit i = requester i.
- `release` input 1: the current owner frees the grant; ignored while `grant_valid`=0.
- `grant_valid` output 1: a grant is active.
- `grant_idx` output 5: index of the current owner; connects to `decoder5to32.A`.
- `timeout` output 1: one-cycle pulse on a forced release. Tied to 0 when `RR_ARB_TIMEOUT_EN` is undefined.

## Operation
State machine, two states: IDLE and GRANT.

Reset (`rst`=1 at an edge) sets:
- state=IDLE
- `ptr`=0
- `grant_valid`=0
- `grant_idx`=0
- `timeout`=0
- hold counter=0

Reset overrides everything else, including mid-grant.

Pick function:
- Search `req` for the first set bit from `ptr` upward, wrapping 31→0.
- The winner is the first set bit found.
- `any` = |`req`.

IDLE:
- If `any`=1: `grant_idx`←winner, `grant_valid`←1, go to GRANT.
- Otherwise stay in IDLE.

GRANT:
- `grant_idx` is frozen; the value of `req` is irrelevant, including when `req[grant_idx]` drops.
- On `release`=1, `ptr`←(`grant_idx`+1) mod 32. Arithmetic is 5-bit and wraps, so 31+1=0.
- Release is back-to-back: in the same edge, the pick is evaluated against the new `ptr` value, computed combinationally.
  - If `any`: `grant_idx`←winner, stay in GRANT, `grant_valid` stays 1.
  - Otherwise: `grant_valid`←0, go to IDLE.
- The previous owner may win again only if it is the sole requester.

`grant_idx` keeps its last value while IDLE. Consumers must qualify it with `grant_valid`.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `grant_valid`=1 after edge N.
- Release-to-next-grant is 0 idle cycles: the new `grant_idx` is visible after the same edge that samples `release`.
- Combinational path: `req`/`ptr`→pick→registers. No output depends combinationally on any input.
- `release` and `rst` asserted in the same cycle: reset wins.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter equals `TIMEOUT-1` and `release`=0, the arbiter performs an internal release identical to `release`=1 and pulses `timeout`=1 for one cycle, aligned with the new grant.
  - A simultaneous real `release` takes precedence: no `timeout` pulse.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout`=0 constant.
  - The grant is held indefinitely until `release`.

## Structure
- Package `rr_arb_pkg` holds:
  - `N_REQ`=32
  - `IDX_W`=5
  - state typedef {IDLE, GRANT}
  - `CNT_W`=8
- Sub-module `rr_pick32` (combinational):
  - Inputs: `req[31:0]`, `ptr[4:0]`.
  - Outputs: `any`, `winner[4:0]`.
  - Implementation: rotate right by `ptr`, priority-encode the lowest set bit, add `ptr` mod 32.
- Top level `rr_arbiter32` holds the FSM, `ptr`, the grant registers and the optional counter.

## Test plan
- Reset, then `req`=0 for 5 cycles → `grant_valid`=0, `grant_idx`=0, `timeout`=0 throughout.
- `req`=0x0000_0012 → after 1 edge `grant_idx`=1. Pulse `release` → `grant_idx`=4 on the next edge with no idle cycle. Pulse `release` again → `grant_idx`=1.
- `req`=0x8000_0001, grant on 31, then `release` → `ptr` wraps to 0, `grant_idx`=0.
- `req`=0xFFFF_FFFF with `release` held high for 40 cycles → `grant_idx` runs 0,1,…,31,0,… with `grant_valid` continuously 1.
- Grant on 7; drop `req[7]` without releasing → `grant_idx` stays 7. Assert `rst` mid-grant → next cycle `grant_valid`=0, `ptr`=0.
- With `RR_ARB_TIMEOUT_EN` and `TIMEOUT`=4: `req`=0x0000_0003, no release → the grant alternates 0→1→0, each held 4 cycles, with a `timeout` pulse at every switch. Without the macro → the grant stays on 0 indefinitely.
